// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU/load/PC+4 result, waits on data memory for loads, drives the register-file write port.
// Optional macro WB_TIMEOUT_EN adds a bounded memory wait with a sticky timeout flag.
module writeback_stage #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_regwrite,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wbsel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc4,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    input  logic        flush,
    output logic        regwrite,
    output logic [4:0]  rd,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        timeout_err
);

    // state    | meaning
    // IDLE     | no entry held, ready to accept
    // WAIT_MEM | load accepted, waiting for dmem_ready
    // COMMIT   | output registers hold a write this cycle, ready to accept
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_COMMIT   = 2'd2
    } state_t;

    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
        $error("writeback_stage: WAIT_MAX must be in 1..255");
    end

    state_t      state_q, state_d;
    logic        accept;
    logic        is_load;
    logic        timeout_hit;
    logic [31:0] wb_data;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        pend_we_q, pend_we_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [2:0]  pend_funct3_q, pend_funct3_d;
    logic [1:0]  pend_off_q, pend_off_d;

    assign accept  = in_valid & in_ready & ~flush;
    assign is_load = (in_wbsel == 2'b01);
    assign wb_data = (in_wbsel == 2'b10) ? in_pc4 : in_alu_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                if (accept) begin
                    state_d = is_load ? S_WAIT_MEM : S_COMMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_MEM: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (dmem_ready) begin
                    state_d = S_COMMIT;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q != S_WAIT_MEM);
        busy     = (state_q == S_WAIT_MEM);
    end

    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (pend_off_q)
            2'd0: byte_sel = dmem_rdata[7:0];
            2'd1: byte_sel = dmem_rdata[15:8];
            2'd2: byte_sel = dmem_rdata[23:16];
            2'd3: byte_sel = dmem_rdata[31:24];
            default: byte_sel = dmem_rdata[7:0];
        endcase
        half_sel = pend_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (pend_funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // The write strobe is only ever set for the cycle that follows entry into COMMIT.
    always_comb begin
        regwrite_d    = 1'b0;
        rd_d          = rd_q;
        rd_data_d     = rd_data_q;
        pend_we_d     = pend_we_q;
        pend_rd_d     = pend_rd_q;
        pend_funct3_d = pend_funct3_q;
        pend_off_d    = pend_off_q;
        if (accept) begin
            if (is_load) begin
                pend_we_d     = in_regwrite;
                pend_rd_d     = in_rd;
                pend_funct3_d = in_funct3;
                pend_off_d    = in_alu_result[1:0];
            end else begin
                regwrite_d = in_regwrite & (in_rd != 5'd0);
                rd_d       = in_rd;
                rd_data_d  = wb_data;
            end
        end else if (state_q == S_WAIT_MEM && !flush && dmem_ready) begin
            regwrite_d = pend_we_q & (pend_rd_q != 5'd0);
            rd_d       = pend_rd_q;
            rd_data_d  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_q    <= 1'b0;
            rd_q          <= '0;
            rd_data_q     <= '0;
            pend_we_q     <= 1'b0;
            pend_rd_q     <= '0;
            pend_funct3_q <= '0;
            pend_off_q    <= '0;
        end else begin
            regwrite_q    <= regwrite_d;
            rd_q          <= rd_d;
            rd_data_q     <= rd_data_d;
            pend_we_q     <= pend_we_d;
            pend_rd_q     <= pend_rd_d;
            pend_funct3_q <= pend_funct3_d;
            pend_off_q    <= pend_off_d;
        end
    end

    assign regwrite = regwrite_q;
    assign rd       = rd_q;
    assign rd_data  = rd_data_q;

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] WAIT_MAX_CNT = 8'(WAIT_MAX);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_cnt_inc;
    logic       timeout_err_q, timeout_err_d;
    logic       waiting_no_data;

    assign waiting_no_data = (state_q == S_WAIT_MEM) && !flush && !dmem_ready;
    assign wait_cnt_inc    = wait_cnt_q + 8'd1;
    // A returning dmem_ready suppresses the increment, so it beats the timeout on the same cycle.
    assign timeout_hit     = waiting_no_data && (wait_cnt_inc == WAIT_MAX_CNT);

    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q | timeout_hit;
        if (accept && is_load) begin
            wait_cnt_d = '0;
        end else if (waiting_no_data) begin
            wait_cnt_d = wait_cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; DUT built with WAIT_MAX=4 so the
// timeout scenario (WB_TIMEOUT_EN) and the ready-on-last-cycle boundary are both reachable.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_regwrite;
    logic [4:0]  in_rd;
    logic [1:0]  in_wbsel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc4;
    logic [2:0]  in_funct3;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        flush;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_data;

    writeback_stage #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_wbsel(in_wbsel), .in_alu_result(in_alu_result),
        .in_pc4(in_pc4), .in_funct3(in_funct3),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .flush(flush),
        .regwrite(regwrite), .rd(rd), .rd_data(rd_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        in_valid = 1'b0; in_regwrite = 1'b0; in_rd = '0; in_wbsel = '0;
        in_alu_result = '0; in_pc4 = '0; in_funct3 = '0;
        dmem_rdata = '0; dmem_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic put_entry(input logic we, input logic [4:0] r, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        in_valid = 1'b1; in_regwrite = we; in_rd = r; in_wbsel = sel;
        in_alu_result = alu; in_pc4 = pc4; in_funct3 = f3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        put_entry(1'b1, 5'd3, 2'b00, 32'h99, 32'h0, 3'b0);
        dmem_ready = 1'b1;
        tick(); tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", regwrite); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b timeout %b want 0 0", busy, timeout_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        quiet_inputs();
        last_rd = 5'd0; last_data = 32'h0;
    endtask

    task automatic test_alu_write();
        put_entry(1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'hFFFF_0000, 3'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (regwrite !== 1'b1 || rd !== 5'd5 || rd_data !== 32'h0000_1234) begin
            errors++; $display("FAIL alu_commit: got we %b rd %0d data %h want 1 5 00001234", regwrite, rd, rd_data); end
        tick();
        checks++; if (regwrite !== 1'b0 || rd !== 5'd5 || rd_data !== 32'h0000_1234) begin
            errors++; $display("FAIL alu_hold: got we %b rd %0d data %h want 0 5 00001234", regwrite, rd, rd_data); end
        // wbsel 11 behaves as ALU
        put_entry(1'b1, 5'd7, 2'b11, 32'hDEAD_BEEF, 32'h0000_0044, 3'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (regwrite !== 1'b1 || rd !== 5'd7 || rd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wbsel11_commit: got we %b rd %0d data %h want 1 7 deadbeef", regwrite, rd, rd_data); end
        // regwrite low entry commits with no strobe
        put_entry(1'b0, 5'd8, 2'b00, 32'h0000_0808, 32'h0, 3'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (regwrite !== 1'b0 || rd !== 5'd8 || rd_data !== 32'h0000_0808) begin
            errors++; $display("FAIL nowrite_commit: got we %b rd %0d data %h want 0 8 00000808", regwrite, rd, rd_data); end
        tick();
        last_rd = 5'd8; last_data = 32'h0000_0808;
    endtask

    task automatic test_x0_write();
        put_entry(1'b1, 5'd0, 2'b10, 32'h1111_1111, 32'h0000_0040, 3'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (regwrite !== 1'b0 || rd !== 5'd0 || rd_data !== 32'h0000_0040) begin
            errors++; $display("FAIL x0_commit: got we %b rd %0d data %h want 0 0 00000040", regwrite, rd, rd_data); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL x0_state: in_ready %b busy %b want 1 0", in_ready, busy); end
        tick();
        last_rd = 5'd0; last_data = 32'h0000_0040;
    endtask

    task automatic run_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] word, input int waits, input logic [31:0] exp,
                            input logic [4:0] r);
        put_entry(1'b1, r, 2'b01, 32'h2000_0000 | {30'd0, off}, 32'h0, f3);
        dmem_rdata = 32'hDEAD_0000;
        tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || regwrite !== 1'b0) begin
            errors++; $display("FAIL %s_enter_wait: busy %b in_ready %b we %b want 1 0 0", name, busy, in_ready, regwrite); end
        for (int i = 0; i < waits; i++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++; if (in_ready !== 1'b0 || regwrite !== 1'b0 || rd !== last_rd || rd_data !== last_data || timeout_err !== 1'b0) begin
                errors++; $display("FAIL %s_wait%0d: in_ready %b we %b rd %0d data %h tmo %b want 0 0 %0d %h 0",
                                   name, i, in_ready, regwrite, rd, rd_data, timeout_err, last_rd, last_data); end
        end
        dmem_ready = 1'b1;
        dmem_rdata = word;
        tick();
        dmem_ready = 1'b0;
        checks++; if (regwrite !== (r != 5'd0) || rd !== r || rd_data !== exp) begin
            errors++; $display("FAIL %s_commit: got we %b rd %0d data %h want %b %0d %h", name, regwrite, rd, rd_data, (r != 5'd0), r, exp); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL %s_after: busy %b in_ready %b tmo %b want 0 1 0", name, busy, in_ready, timeout_err); end
        last_rd = r; last_data = exp;
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL %s_pulse: regwrite got %b want 0", name, regwrite); end
    endtask

    task automatic test_load_extend();
        // three empty wait cycles puts dmem_ready on the cycle the counter would reach WAIT_MAX
        run_load("lb",    3'b000, 2'd2, 32'h0080_FF00, 3, 32'hFFFF_FF80, 5'd9);
        run_load("lbu",   3'b100, 2'd2, 32'h0080_FF00, 3, 32'h0000_0080, 5'd10);
        run_load("lb3",   3'b000, 2'd3, 32'h7F00_0000, 0, 32'h0000_007F, 5'd11);
        run_load("lh",    3'b001, 2'd2, 32'h8001_1234, 1, 32'hFFFF_8001, 5'd12);
        run_load("lhu",   3'b101, 2'd0, 32'h8001_F234, 2, 32'h0000_F234, 5'd13);
        run_load("lw",    3'b010, 2'd1, 32'hCAFE_BABE, 0, 32'hCAFE_BABE, 5'd14);
        run_load("f3_11", 3'b011, 2'd3, 32'h1234_5678, 1, 32'h1234_5678, 5'd15);
        run_load("ld_x0", 3'b010, 2'd0, 32'h5555_AAAA, 0, 32'h5555_AAAA, 5'd0);
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [3] = '{5'd1, 5'd2, 5'd3};
        logic [1:0]  sels [3] = '{2'b00, 2'b10, 2'b00};
        logic [31:0] exps [3] = '{32'h0000_0111, 32'h0000_0222, 32'h0000_0333};
        for (int i = 0; i < 3; i++) begin
            put_entry(1'b1, rds[i], sels[i], (sels[i] == 2'b10) ? 32'hBAD0_0000 : exps[i],
                      (sels[i] == 2'b10) ? exps[i] : 32'hBAD1_0000, 3'b0);
            tick();
            checks++; if (regwrite !== 1'b1 || rd !== rds[i] || rd_data !== exps[i] || in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_%0d: got we %b rd %0d data %h rdy %b want 1 %0d %h 1",
                                   i, regwrite, rd, rd_data, in_ready, rds[i], exps[i]); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (regwrite !== 1'b0 || rd !== 5'd3 || rd_data !== 32'h0000_0333) begin
            errors++; $display("FAIL b2b_end: got we %b rd %0d data %h want 0 3 00000333", regwrite, rd, rd_data); end
        last_rd = 5'd3; last_data = 32'h0000_0333;
    endtask

    task automatic test_flush();
        put_entry(1'b1, 5'd20, 2'b01, 32'h0, 32'h0, 3'b010);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h7777_7777;
        put_entry(1'b1, 5'd21, 2'b00, 32'h6666_6666, 32'h0, 3'b0);
        tick();
        flush = 1'b0; dmem_ready = 1'b0; in_valid = 1'b0;
        checks++; if (regwrite !== 1'b0 || rd !== last_rd || rd_data !== last_data) begin
            errors++; $display("FAIL flush_wait: got we %b rd %0d data %h want 0 %0d %h", regwrite, rd, rd_data, last_rd, last_data); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: busy %b in_ready %b want 0 1", busy, in_ready); end
        tick();
        checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL flush_late: regwrite got %b want 0", regwrite); end
        put_entry(1'b1, 5'd11, 2'b00, 32'h0000_0055, 32'h0, 3'b0);
        tick();
        checks++; if (regwrite !== 1'b1 || rd !== 5'd11 || rd_data !== 32'h0000_0055) begin
            errors++; $display("FAIL flush_next: got we %b rd %0d data %h want 1 11 00000055", regwrite, rd, rd_data); end
        // flush while COMMIT is showing: current write stands, the offered entry is dropped
        flush = 1'b1;
        put_entry(1'b1, 5'd12, 2'b00, 32'h0000_0099, 32'h0, 3'b0);
        checks++; if (regwrite !== 1'b1 || rd !== 5'd11) begin
            errors++; $display("FAIL flush_commit_keep: got we %b rd %0d want 1 11", regwrite, rd); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (regwrite !== 1'b0 || rd !== 5'd11 || rd_data !== 32'h0000_0055 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_commit_drop: got we %b rd %0d data %h busy %b want 0 11 00000055 0", regwrite, rd, rd_data, busy); end
        last_rd = 5'd11; last_data = 32'h0000_0055;
    endtask

    task automatic test_reset_mid_wait();
        put_entry(1'b1, 5'd4, 2'b01, 32'h0, 32'h0, 3'b010);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF; flush = 1'b1;
        tick();
        rst_n = 1'b1; dmem_ready = 1'b0; flush = 1'b0;
        checks++; if (regwrite !== 1'b0 || rd !== 5'd0 || rd_data !== 32'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_wait: got we %b rd %0d data %h busy %b want 0 0 0 0", regwrite, rd, rd_data, busy); end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        checks++; if (regwrite !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_wait_after: we %b in_ready %b want 0 1", regwrite, in_ready); end
        last_rd = 5'd0; last_data = 32'h0;
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        put_entry(1'b1, 5'd6, 2'b01, 32'h0, 32'h0, 3'b010);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
                    errors++; $display("FAIL tmo_wait%0d: busy %b tmo %b want 1 0", i, busy, timeout_err); end
            end
        end
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || regwrite !== 1'b0 || rd !== last_rd) begin
            errors++; $display("FAIL tmo_fire: tmo %b busy %b rdy %b we %b rd %0d want 1 0 1 0 %0d", timeout_err, busy, in_ready, regwrite, rd, last_rd); end
        put_entry(1'b1, 5'd2, 2'b00, 32'h0000_00AB, 32'h0, 3'b0);
        tick();
        in_valid = 1'b0;
        checks++; if (timeout_err !== 1'b1 || regwrite !== 1'b1 || rd_data !== 32'h0000_00AB) begin
            errors++; $display("FAIL tmo_sticky: tmo %b we %b data %h want 1 1 000000ab", timeout_err, regwrite, rd_data); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (timeout_err !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL tmo_reset: tmo %b data %h want 0 0", timeout_err, rd_data); end
    endtask
`else
    task automatic test_timeout();
        put_entry(1'b1, 5'd6, 2'b01, 32'h0, 32'h0, 3'b010);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        checks++; if (busy !== 1'b1 || timeout_err !== 1'b0 || regwrite !== 1'b0) begin
            errors++; $display("FAIL no_tmo_wait: busy %b tmo %b we %b want 1 0 0", busy, timeout_err, regwrite); end
        dmem_ready = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        tick();
        dmem_ready = 1'b0;
        checks++; if (regwrite !== 1'b1 || rd !== 5'd6 || rd_data !== 32'h0BAD_F00D || timeout_err !== 1'b0) begin
            errors++; $display("FAIL no_tmo_commit: we %b rd %0d data %h tmo %b want 1 6 0badf00d 0", regwrite, rd, rd_data, timeout_err); end
    endtask
`endif

    initial begin
        quiet_inputs();
        rst_n = 1'b0;
        test_reset();
        test_alu_write();
        test_x0_write();
        test_load_extend();
        test_back_to_back();
        test_flush();
        test_reset_mid_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
